// File: rtl/cart_arb_pkg.sv
// Shared types and constants for the cartridge memory arbiter.
package cart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    LD = 2'd0,
    C0 = 2'd1,
    C1 = 2'd2
  } req_id_e;

  localparam logic [7:0] RDATA_TIMEOUT = 8'hFF;
  localparam req_id_e    RR_RESET      = C0;

  // One-hot ack vector {c1, c0, ld} for a requester ID.
  function automatic logic [2:0] id_onehot(input req_id_e id);
    logic [2:0] v;
    case (id)
      LD:      v = 3'b001;
      C0:      v = 3'b010;
      C1:      v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cart_arb_watchdog.sv
// BUSY-cycle watchdog: counts cycles while run is high and flags the
// TIMEOUT-th consecutive cycle. Clears whenever run is low.
module cart_arb_watchdog
  import cart_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  // Cycle counter: advances during a run, returns to zero otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 8'd0;
    end else if (run) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= 8'd0;
    end
  end

  // cnt holds k-1 during the k-th running cycle.
  assign expired = run && (cnt == LAST);

endmodule

// File: rtl/cart_mem_arbiter.sv
// Cartridge memory arbiter: loader (fixed top priority) and two mapper
// slots (round-robin) share one external memory port. A transaction is
// IDLE grant -> BUSY until mem_ack or watchdog -> DONE one-cycle ack.
// Optional feature macro: CART_ARB_SLOT2_EN enables arbitration of slot 1;
// without it the c1_* inputs are ignored and c1_ack is tied low.
module cart_mem_arbiter
  import cart_arb_pkg::*;
#(
  parameter int ADDR_W  = 25,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_din,
  output logic              ld_ack,
  input  logic              c0_req,
  input  logic              c0_we,
  input  logic              c0_en,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [7:0]        c0_din,
  output logic              c0_ack,
  input  logic              c1_req,
  input  logic              c1_we,
  input  logic              c1_en,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [7:0]        c1_din,
  output logic              c1_ack,
  output logic [7:0]        rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic              mem_ack,
  input  logic [7:0]        mem_dout
);

  arb_state_e        state, state_nxt;
  req_id_e           winner, rr_ptr, grant_id;
  logic              grant_valid;
  logic              ld_elig, c0_elig, c1_elig;
  logic              wd_expired;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_din;
  logic [2:0]        ack;

  assign ld_elig = ld_req;
  assign c0_elig = c0_req & c0_en;
  assign ld_ack  = ack[0];
  assign c0_ack  = ack[1];

`ifdef CART_ARB_SLOT2_EN
  assign c1_elig = c1_req & c1_en;
  assign c1_ack  = ack[2];
`else
  logic unused_c1;
  assign c1_elig   = 1'b0;
  assign c1_ack    = 1'b0;
  assign unused_c1 = &{1'b0, c1_req, c1_we, c1_en, c1_addr, c1_din, ack[2]};
`endif

  cart_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (state == BUSY),
    .expired (wd_expired)
  );

  // Arbitration: loader first, then slots with round-robin tie-break.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = LD;
    if (ld_elig) begin
      grant_valid = 1'b1;
      grant_id    = LD;
    end else if (c0_elig && c1_elig) begin
      grant_valid = 1'b1;
      grant_id    = rr_ptr;
    end else if (c0_elig) begin
      grant_valid = 1'b1;
      grant_id    = C0;
    end else if (c1_elig) begin
      grant_valid = 1'b1;
      grant_id    = C1;
    end else begin
      grant_valid = 1'b0;
      grant_id    = LD;
    end
  end

  // Request fields of the current arbitration winner.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = {ADDR_W{1'b0}};
    sel_din  = 8'h00;
    case (grant_id)
      LD: begin
        sel_we   = ld_we;
        sel_addr = ld_addr;
        sel_din  = ld_din;
      end
      C0: begin
        sel_we   = c0_we;
        sel_addr = c0_addr;
        sel_din  = c0_din;
      end
      C1: begin
        sel_we   = c1_we;
        sel_addr = c1_addr;
        sel_din  = c1_din;
      end
      default: begin
        sel_we   = 1'b0;
        sel_addr = {ADDR_W{1'b0}};
        sel_din  = 8'h00;
      end
    endcase
  end

  // Next-state logic; mem_ack is checked before the watchdog so it wins a tie.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_valid) state_nxt = BUSY;
        else             state_nxt = IDLE;
      end
      BUSY: begin
        if (mem_ack || wd_expired) state_nxt = DONE;
        else                       state_nxt = BUSY;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Registered memory port, result and ack outputs plus round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= {ADDR_W{1'b0}};
      mem_din  <= 8'h00;
      rdata    <= 8'h00;
      err      <= 1'b0;
      ack      <= 3'b000;
      winner   <= LD;
      rr_ptr   <= RR_RESET;
    end else begin
      case (state)
        IDLE: begin
          ack <= 3'b000;
          if (grant_valid) begin
            mem_req  <= 1'b1;
            mem_we   <= sel_we;
            mem_addr <= sel_addr;
            mem_din  <= sel_din;
            winner   <= grant_id;
            if (grant_id == C0)      rr_ptr <= C1;
            else if (grant_id == C1) rr_ptr <= C0;
            else                     rr_ptr <= rr_ptr;
          end else begin
            mem_req <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            rdata   <= mem_dout;
            err     <= 1'b0;
            ack     <= id_onehot(winner);
          end else if (wd_expired) begin
            mem_req <= 1'b0;
            rdata   <= RDATA_TIMEOUT;
            err     <= 1'b1;
            ack     <= id_onehot(winner);
          end else begin
            mem_req <= 1'b1;
            ack     <= 3'b000;
          end
        end
        DONE: begin
          mem_req <= 1'b0;
          ack     <= 3'b000;
        end
        default: begin
          mem_req <= 1'b0;
          ack     <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed self-checking bench for cart_mem_arbiter (TIMEOUT=16).
module tb_cart_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ld_req, ld_we;
  logic [24:0] ld_addr;
  logic [7:0]  ld_din;
  logic        ld_ack;
  logic        c0_req, c0_we, c0_en;
  logic [24:0] c0_addr;
  logic [7:0]  c0_din;
  logic        c0_ack;
  logic        c1_req, c1_we, c1_en;
  logic [24:0] c1_addr;
  logic [7:0]  c1_din;
  logic        c1_ack;
  logic [7:0]  rdata;
  logic        err;
  logic        mem_req, mem_we;
  logic [24:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_ack;
  logic [7:0]  mem_dout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cart_mem_arbiter #(.ADDR_W(25), .TIMEOUT(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_din(ld_din), .ld_ack(ld_ack),
    .c0_req(c0_req), .c0_we(c0_we), .c0_en(c0_en), .c0_addr(c0_addr), .c0_din(c0_din), .c0_ack(c0_ack),
    .c1_req(c1_req), .c1_we(c1_we), .c1_en(c1_en), .c1_addr(c1_addr), .c1_din(c1_din), .c1_ack(c1_ack),
    .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_ack(mem_ack), .mem_dout(mem_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ld_req = 1'b0; ld_we = 1'b0; ld_addr = 25'h0; ld_din = 8'h00;
    c0_req = 1'b0; c0_we = 1'b0; c0_en = 1'b0; c0_addr = 25'h0; c0_din = 8'h00;
    c1_req = 1'b0; c1_we = 1'b0; c1_en = 1'b0; c1_addr = 25'h0; c1_din = 8'h00;
    mem_ack = 1'b0; mem_dout = 8'h00;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    repeat (3) tick();
    n_checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 25'h0 || mem_din !== 8'h00) begin
      $display("FAIL reset_mem: req=%b we=%b addr=%h din=%h, expected all 0", mem_req, mem_we, mem_addr, mem_din);
      n_fail++;
    end
    n_checks++;
    if ({ld_ack, c0_ack, c1_ack} !== 3'b000 || rdata !== 8'h00 || err !== 1'b0) begin
      $display("FAIL reset_out: acks=%b rdata=%h err=%b, expected 0", {ld_ack, c0_ack, c1_ack}, rdata, err);
      n_fail++;
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_priority();
    logic [24:0] got[$];
    int a_ld = 0, a_c0 = 0, a_c1 = 0, multi = 0, exp_n;
    logic prev_req = 1'b0;
    ld_req = 1'b1; ld_addr = 25'h10;
    c0_req = 1'b1; c0_en = 1'b1; c0_addr = 25'h20;
    c1_req = 1'b1; c1_en = 1'b1; c1_addr = 25'h30;
    mem_ack = 1'b1; mem_dout = 8'h11;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (mem_req && !prev_req) got.push_back(mem_addr);
      if (int'(ld_ack) + int'(c0_ack) + int'(c1_ack) > 1) multi++;
      if (ld_ack) begin a_ld++; ld_req = 1'b0; end
      if (c0_ack) begin a_c0++; c0_req = 1'b0; end
      if (c1_ack) begin a_c1++; c1_req = 1'b0; end
      prev_req = mem_req;
    end
`ifdef CART_ARB_SLOT2_EN
    exp_n = 3;
`else
    exp_n = 2;
`endif
    n_checks++;
    if (got.size() !== exp_n) begin
      $display("FAIL prio_grants: %0d grants, expected %0d", got.size(), exp_n);
      n_fail++;
    end
    n_checks++;
    if (got.size() < 2 || got[0] !== 25'h10 || got[1] !== 25'h20) begin
      $display("FAIL prio_order: first grants %h,%h expected 10,20", got.size() > 0 ? got[0] : 25'h0, got.size() > 1 ? got[1] : 25'h0);
      n_fail++;
    end
`ifdef CART_ARB_SLOT2_EN
    n_checks++;
    if (got.size() < 3 || got[2] !== 25'h30) begin
      $display("FAIL prio_c1: third grant missing or wrong, expected 30");
      n_fail++;
    end
`endif
    n_checks++;
    if (a_ld !== 1 || a_c0 !== 1 || a_c1 !== exp_n - 2 || multi !== 0) begin
      $display("FAIL prio_acks: ld=%0d c0=%0d c1=%0d multi=%0d, expected 1/1/%0d/0", a_ld, a_c0, a_c1, multi, exp_n - 2);
      n_fail++;
    end
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_single_read();
    c0_req = 1'b1; c0_en = 1'b1; c0_we = 1'b0; c0_addr = 25'h000100;
    tick();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 25'h000100 || mem_we !== 1'b0) begin
      $display("FAIL read_grant: req=%b addr=%h we=%b, expected 1/000100/0", mem_req, mem_addr, mem_we);
      n_fail++;
    end
    c0_req = 1'b0; c0_en = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 25'h000100 || c0_ack !== 1'b0) begin
      $display("FAIL read_hold: req=%b addr=%h ack=%b, expected 1/000100/0", mem_req, mem_addr, c0_ack);
      n_fail++;
    end
    mem_ack = 1'b1; mem_dout = 8'h5A;
    tick();
    mem_ack = 1'b0; mem_dout = 8'h00;
    n_checks++;
    if (c0_ack !== 1'b1 || ld_ack !== 1'b0 || c1_ack !== 1'b0 || rdata !== 8'h5A || err !== 1'b0 || mem_req !== 1'b0) begin
      $display("FAIL read_done: c0_ack=%b rdata=%h err=%b req=%b, expected 1/5a/0/0", c0_ack, rdata, err, mem_req);
      n_fail++;
    end
    tick();
    n_checks++;
    if (c0_ack !== 1'b0 || rdata !== 8'h5A) begin
      $display("FAIL read_pulse: c0_ack=%b rdata=%h, expected 0/5a", c0_ack, rdata);
      n_fail++;
    end
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    int cnt = 1;
    c0_req = 1'b1; c0_en = 1'b1; c0_we = 1'b1; c0_addr = 25'h1ABCDEF; c0_din = 8'hC3;
    tick();
    n_checks++;
    if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_din !== 8'hC3 || mem_addr !== 25'h1ABCDEF) begin
      $display("FAIL to_grant: req=%b we=%b din=%h addr=%h", mem_req, mem_we, mem_din, mem_addr);
      n_fail++;
    end
    c0_req = 1'b0; c0_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!mem_req) break;
      cnt++;
    end
    n_checks++;
    if (cnt !== 16) begin
      $display("FAIL to_len: mem_req high %0d cycles, expected 16", cnt);
      n_fail++;
    end
    n_checks++;
    if (c0_ack !== 1'b1 || rdata !== 8'hFF || err !== 1'b1) begin
      $display("FAIL to_result: c0_ack=%b rdata=%h err=%b, expected 1/ff/1", c0_ack, rdata, err);
      n_fail++;
    end
    repeat (2) tick();
  endtask

  task automatic test_ack_race();
    c0_req = 1'b1; c0_en = 1'b1; c0_we = 1'b0; c0_addr = 25'h222;
    tick();
    c0_req = 1'b0;
    repeat (15) tick();
    n_checks++;
    if (mem_req !== 1'b1) begin
      $display("FAIL race_busy16: mem_req=%b in 16th busy cycle, expected 1", mem_req);
      n_fail++;
    end
    mem_ack = 1'b1; mem_dout = 8'h3C;
    tick();
    mem_ack = 1'b0;
    n_checks++;
    if (c0_ack !== 1'b1 || err !== 1'b0 || rdata !== 8'h3C) begin
      $display("FAIL race_result: c0_ack=%b err=%b rdata=%h, expected 1/0/3c", c0_ack, err, rdata);
      n_fail++;
    end
    repeat (2) tick();
  endtask

  task automatic test_idle_ack();
    int bad = 0;
    mem_ack = 1'b1; mem_dout = 8'h77;
    repeat (4) begin
      tick();
      if (mem_req !== 1'b0 || {ld_ack, c0_ack, c1_ack} !== 3'b000) bad++;
    end
    mem_ack = 1'b0;
    n_checks++;
    if (bad !== 0 || rdata !== 8'h3C) begin
      $display("FAIL idle_ack: bad cycles=%0d rdata=%h, expected 0/3c", bad, rdata);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0, rises = 0, first_rise = -1, first_ack = -1, overlap = 0;
    logic prev_req = 1'b0;
    c0_req = 1'b1; c0_en = 1'b1; c0_addr = 25'h44;
    mem_ack = 1'b1; mem_dout = 8'h42;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (mem_req && !prev_req) begin rises++; if (first_rise < 0) first_rise = i; end
      if (c0_ack) begin acks++; if (first_ack < 0) first_ack = i; end
      if (c0_ack && mem_req) overlap++;
      prev_req = mem_req;
    end
    n_checks++;
    if (first_rise !== 1 || first_ack !== 2) begin
      $display("FAIL b2b_latency: rise@%0d ack@%0d, expected 1/2", first_rise, first_ack);
      n_fail++;
    end
    n_checks++;
    if (acks !== 4 || rises !== 4 || overlap !== 0) begin
      $display("FAIL b2b_count: acks=%0d grants=%0d overlap=%0d, expected 4/4/0", acks, rises, overlap);
      n_fail++;
    end
    clear_inputs();
    repeat (3) tick();
  endtask

  task automatic test_c1_gated();
    int bad = 0;
    logic [24:0] exp_addr;
    logic exp_req;
    c1_req = 1'b1; c1_en = 1'b0; c1_addr = 25'h66;
    repeat (20) begin
      tick();
      if (mem_req !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      $display("FAIL c1_disabled: mem_req seen %0d cycles, expected 0", bad);
      n_fail++;
    end
    c1_en = 1'b1;
    tick();
`ifdef CART_ARB_SLOT2_EN
    exp_req = 1'b1; exp_addr = 25'h66;
`else
    exp_req = 1'b0; exp_addr = 25'h0;
`endif
    n_checks++;
    if (mem_req !== exp_req || (exp_req && mem_addr !== exp_addr)) begin
      $display("FAIL c1_enable: mem_req=%b addr=%h, expected %b/%h", mem_req, mem_addr, exp_req, exp_addr);
      n_fail++;
    end
    c1_req = 1'b0; c1_en = 1'b0;
    mem_ack = 1'b1;
    repeat (3) tick();
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_reset_busy();
    int bad = 0;
    logic [24:0] exp_addr;
    c0_req = 1'b1; c0_en = 1'b1; c0_we = 1'b0; c0_addr = 25'h55;
    tick();
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 25'h55) begin
      $display("FAIL rb_grant: req=%b addr=%h, expected 1/55", mem_req, mem_addr);
      n_fail++;
    end
    c0_req = 1'b0;
    c1_req = 1'b1; c1_en = 1'b1; c1_addr = 25'h66;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || {ld_ack, c0_ack, c1_ack} !== 3'b000) begin
      $display("FAIL rb_async: mem_req=%b acks=%b right after reset, expected 0/000", mem_req, {ld_ack, c0_ack, c1_ack});
      n_fail++;
    end
`ifdef CART_ARB_SLOT2_EN
    exp_addr = 25'h66;
`else
    c0_req = 1'b1; c0_addr = 25'h77;
    exp_addr = 25'h77;
`endif
    repeat (2) begin
      tick();
      if ({ld_ack, c0_ack, c1_ack} !== 3'b000 || mem_req !== 1'b0) bad++;
    end
    reset_n = 1'b1;
    tick();
    if ({ld_ack, c0_ack, c1_ack} !== 3'b000) bad++;
    n_checks++;
    if (bad !== 0) begin
      $display("FAIL rb_noack: %0d cycles with ack or mem_req during/after reset, expected 0", bad);
      n_fail++;
    end
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== exp_addr) begin
      $display("FAIL rb_regrant: req=%b addr=%h, expected 1/%h", mem_req, mem_addr, exp_addr);
      n_fail++;
    end
    clear_inputs();
    mem_ack = 1'b1;
    repeat (3) tick();
    mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_both_slots();
    int a0 = 0, a1 = 0;
    c0_req = 1'b1; c0_en = 1'b1; c0_addr = 25'h80;
    c1_req = 1'b1; c1_en = 1'b1; c1_addr = 25'h90;
    mem_ack = 1'b1; mem_dout = 8'h01;
    repeat (15) begin
      tick();
      if (c0_ack) a0++;
      if (c1_ack) a1++;
    end
    n_checks++;
`ifdef CART_ARB_SLOT2_EN
    if (a0 + a1 !== 5 || a0 < 2 || a1 < 2) begin
      $display("FAIL slots_rr: c0 acks=%0d c1 acks=%0d, expected alternating total 5", a0, a1);
      n_fail++;
    end
`else
    if (a0 !== 5 || a1 !== 0) begin
      $display("FAIL slots_c0only: c0 acks=%0d c1 acks=%0d, expected 5/0", a0, a1);
      n_fail++;
    end
`endif
    clear_inputs();
    repeat (3) tick();
  endtask

  initial begin
    clear_inputs();
    reset_n = 1'b1;
    test_reset();
    test_priority();
    test_single_read();
    test_timeout();
    test_ack_race();
    test_idle_ack();
    test_back_to_back();
    test_c1_gated();
    test_reset_busy();
    test_both_slots();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cart_mem_arbiter.md
CART_MEM_ARBITER -- requirements
Module: cart_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 25: byte address width of the shared memory port.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum BUSY cycles before abort, range 1..255.
REQ-003 SHALL have port clk, input, 1: single clock for the whole block.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have ports ld_req / ld_we / ld_addr / ld_din, input, 1/1/ADDR_W/8: loader request.
REQ-006 SHALL have port ld_ack, output, 1: loader completion pulse.
REQ-007 SHALL have ports cN_req / cN_we / cN_en, input, 1 each, N=0,1: slot N request, write, slot enabled by the mapper decoder.
REQ-008 SHALL have ports cN_addr / cN_din, input, ADDR_W/8, N=0,1: slot N address and write data.
REQ-009 SHALL have port cN_ack, output, 1, N=0,1: slot N completion pulse.
REQ-010 SHALL have ports rdata / err, output, 8/1: read data and timeout flag, valid in the cycle any ack is high.
REQ-011 SHALL have ports mem_req / mem_we / mem_addr / mem_din, output, 1/1/ADDR_W/8: external memory request.
REQ-012 SHALL have ports mem_ack / mem_dout, input, 1/8: external memory completion and read data.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 IDLE: a request is eligible when ld_req=1, or when cN_req=1 and cN_en=1.
REQ-015 IDLE: loader has fixed top priority; c0 and c1 alternate round-robin; the slot not granted last wins a tie.
REQ-016 IDLE with a winner: latch we/addr/din and winner ID, assert mem_req at the next edge, enter BUSY.
REQ-017 BUSY: hold mem_req=1 and all mem_* outputs stable until mem_ack=1.
REQ-018 BUSY: on mem_ack=1, capture mem_dout into rdata, err=0, drop mem_req at the next edge, enter DONE.
REQ-019 BUSY: the watchdog counts cycles; at the TIMEOUT-th cycle with no mem_ack, drop mem_req, rdata=8'hFF, err=1, enter DONE.
REQ-020 DONE: pulse the winner's ack for exactly one cycle, then enter IDLE; rdata and err hold until the next DONE.
REQ-021 Minimum transaction is 3 cycles: request at IDLE edge n, mem_req at n+1, mem_ack at n+1, ack at n+2.
REQ-022 Back-to-back requests: a new grant occurs in the IDLE cycle after DONE; no request is granted twice per ack.
REQ-023 A requester dropping req, or cN_en falling, mid-transaction SHALL NOT abort it; the ack is still pulsed.
REQ-024 mem_ack arriving in IDLE or DONE SHALL be ignored.
REQ-025 mem_ack in the same cycle the watchdog expires: mem_ack wins, err=0.
REQ-026 At most one ack output SHALL be high in any cycle.
REQ-027 Writes SHALL return rdata=mem_dout as sampled, with no meaning attached.

Reset
REQ-028 reset_n=0 SHALL asynchronously force state=IDLE, all outputs 0, the round-robin pointer to favour c0, and the watchdog to 0.
REQ-029 Reset mid-BUSY SHALL drop mem_req immediately; the interrupted requester receives no ack.

Configuration
REQ-030 With macro CART_ARB_SLOT2_EN defined, slot 1 SHALL arbitrate as above.
REQ-031 Without CART_ARB_SLOT2_EN, c1_* inputs SHALL be ignored, c1_ack SHALL be constant 0, and c0 SHALL be granted whenever eligible and the loader is idle.

Structure
REQ-032 Package cart_arb_pkg SHALL hold the FSM state enum, the requester-ID enum (LD, C0, C1), and the constants RDATA_TIMEOUT=8'hFF and RR_RESET=C0.
REQ-033 The watchdog counter SHALL be sub-module cart_arb_watchdog (clk, reset_n, run, expired).

Verification
REQ-034 c0 read addr 0x000100, mem_ack 4 cycles after mem_req with mem_dout 0x5A -> one c0_ack pulse, rdata=0x5A, err=0.
REQ-035 ld, c0, c1 request in the same cycle, mem_ack after 1 cycle each -> grant order LD, C0, C1; three single acks; mem_req low at least one cycle between grants.
REQ-036 c1_req=1 with c1_en=0, repeated for 20 cycles -> no mem_req; then set c1_en=1 -> grant on the next IDLE cycle.
REQ-037 c0 write with mem_ack never given, TIMEOUT=16 -> mem_req drops after 16 BUSY cycles, c0_ack with rdata=0xFF, err=1.
REQ-038 reset_n low 2 cycles into BUSY -> mem_req=0 asynchronously, no ack; after release a held c1 request is granted.
REQ-039 CART_ARB_SLOT2_EN undefined, c0 and c1 both requesting continuously -> only c0_ack pulses; c1_ack stays 0.
